// File: rtl/mw_freelist_ckpt.sv
// Multi-way physical-register freelist with a committed head for one-cycle flush recovery.
// Optional FREELIST_CHECK_EN builds the sticky err_o checker; otherwise err_o is tied low.
module mw_freelist_ckpt #(
  parameter int NUM_PREG    = 64,
  parameter int PREG_W      = 6,
  parameter int ALLOC_WAYS  = 4,
  parameter int FREE_WAYS   = 4,
  parameter int COMMIT_WAYS = 4,
  parameter int CNT_W       = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ALLOC_WAYS-1:0]        alloc_req_i,
  output logic                         alloc_rdy_o,
  output logic [ALLOC_WAYS*PREG_W-1:0] alloc_tag_o,
  input  logic [FREE_WAYS-1:0]         free_vld_i,
  input  logic [FREE_WAYS*PREG_W-1:0]  free_tag_i,
  input  logic [COMMIT_WAYS-1:0]       commit_vld_i,
  input  logic                         flush_i,
  output logic [CNT_W:0]               count_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         err_o
);

  localparam int DEPTH = NUM_PREG - 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = CNT_W + 2;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W:0]   cnt_t;
  typedef logic [SUM_W-1:0] sum_t;

  localparam sum_t DEPTH_S = sum_t'(DEPTH);
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  // Ring pointers wrap at DEPTH, which is generally not a power of two.
  function automatic ptr_t ptrAdd(input ptr_t p, input cnt_t k);
    sum_t s;
    s = sum_t'(p) + sum_t'(k);
    if (s >= DEPTH_S) s = s - DEPTH_S;
    return s[PTR_W-1:0];
  endfunction

  logic [PREG_W-1:0] r_entry [DEPTH];
  ptr_t              r_head;
  ptr_t              r_commitHead;
  ptr_t              r_tail;
  cnt_t              r_count;
  cnt_t              r_commitCount;

  cnt_t w_na;
  cnt_t w_naG;
  cnt_t w_nf;
  cnt_t w_nc;
  ptr_t w_freeIdx [FREE_WAYS];
  ptr_t w_commitHeadNext;

  always_comb begin
    w_na        = '0;
    alloc_tag_o = '0;
    for (int i = 0; i < ALLOC_WAYS; i++) begin
      if (alloc_req_i[i]) begin
        alloc_tag_o[i*PREG_W +: PREG_W] = r_entry[ptrAdd(r_head, w_na)];
        w_na = w_na + cnt_t'(1);
      end
    end
  end

  always_comb begin
    w_nf = '0;
    for (int j = 0; j < FREE_WAYS; j++) begin
      w_freeIdx[j] = ptrAdd(r_tail, w_nf);
      if (free_vld_i[j]) w_nf = w_nf + cnt_t'(1);
    end
  end

  always_comb begin
    w_nc = '0;
    for (int c = 0; c < COMMIT_WAYS; c++) begin
      if (commit_vld_i[c]) w_nc = w_nc + cnt_t'(1);
    end
  end

  assign alloc_rdy_o      = !flush_i && (r_count >= w_na);
  assign w_naG            = alloc_rdy_o ? w_na : '0;
  assign w_commitHeadNext = ptrAdd(r_commitHead, w_nc);

  assign count_o = r_count;
  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == DEPTH_C);

  // A flush rebuilds the speculative view from the committed one after this cycle's commits and frees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= PREG_W'(i + 1);
      r_head        <= '0;
      r_commitHead  <= '0;
      r_tail        <= '0;
      r_count       <= DEPTH_C;
      r_commitCount <= DEPTH_C;
    end else begin
      for (int j = 0; j < FREE_WAYS; j++) begin
        if (free_vld_i[j]) r_entry[w_freeIdx[j]] <= free_tag_i[j*PREG_W +: PREG_W];
      end
      r_tail        <= ptrAdd(r_tail, w_nf);
      r_commitHead  <= w_commitHeadNext;
      r_commitCount <= r_commitCount - w_nc + w_nf;
      if (flush_i) begin
        r_head  <= w_commitHeadNext;
        r_count <= r_commitCount - w_nc + w_nf;
      end else begin
        r_head  <= ptrAdd(r_head, w_naG);
        r_count <= r_count - w_naG + w_nf;
      end
    end
  end

`ifdef FREELIST_CHECK_EN
  logic r_err;
  logic w_errEvt;

  // Signed arithmetic so that illegal commits show up as negative rather than wrapping.
  assign w_errEvt = ((int'(r_count) - int'(w_naG) + int'(w_nf)) > DEPTH) ||
                    ((int'(r_commitCount) - int'(w_nc) + int'(w_nf)) > DEPTH) ||
                    (int'(w_nc) > (int'(r_commitCount) - int'(r_count)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      if (w_errEvt) begin
        r_err <= 1'b1;
        $error("mw_freelist_ckpt: overflow or commit of unallocated entry");
      end
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule
